pixel_clk_gen: RTL and testbench

Parametrised pixel-rate enable generator; successor to the fixed divide-by-4 pixel clock. Divides the system clock by a runtime-selectable divisor and produces a one-cycle pixel enable, a near-50% pixel clock level, the current phase and a locked flag. Start/stop sequencing ensures the last pixel period always completes. Feeds the horizontal/vertical timing counters and the pixel datapath.

---
 rtl/pixel_clk_gen.sv | 85 ++++++++
 tb/tb_pixel_clk_gen.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pixel_clk_gen.sv
// Pixel-rate enable generator: divides clock by a runtime divisor, emits a one-cycle
// pixel enable, a near-50% pixel clock level, phase and lock status.
module pixel_clk_gen #(
    parameter int CNT_WIDTH   = 4,
    parameter int DEFAULT_DIV = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [CNT_WIDTH-1:0] divIn,
    output logic                 pixelEn,
    output logic                 pixelClk,
    output logic [CNT_WIDTH-1:0] phase,
    output logic                 locked,
    output logic                 busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]           r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_div;
    logic                 r_locked;

    logic                 w_busy;
    logic                 w_term;
    logic [CNT_WIDTH-1:0] w_eff_div;

    assign w_busy    = (r_state != S_IDLE);
    assign w_term    = (r_cnt == (r_div - CNT_WIDTH'(1)));
    // A zero divisor request behaves as divide-by-1 so the terminal compare stays valid.
    assign w_eff_div = (divIn == '0) ? CNT_WIDTH'(1) : divIn;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_div    <= CNT_WIDTH'(DEFAULT_DIV);
            r_locked <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt    <= '0;
                    r_locked <= 1'b0;
                    if (enable) begin
                        r_state <= S_RUN;
                        r_div   <= w_eff_div;
                    end
                end
                S_RUN, S_DRAIN: begin
                    if (w_term) begin
                        r_cnt    <= '0;
                        r_div    <= w_eff_div;
                        r_locked <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                    end
                    // Stopping waits for the current period to finish; a term edge ends it now.
                    if (enable) begin
                        r_state <= S_RUN;
                    end else if (w_term) begin
                        r_state  <= S_IDLE;
                        r_locked <= 1'b0;
                    end else begin
                        r_state <= S_DRAIN;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_cnt    <= '0;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = w_busy;
    assign pixelEn  = w_busy && w_term;
    assign pixelClk = w_busy && (r_cnt >= (r_div >> 1));
    assign phase    = w_busy ? r_cnt : '0;
    assign locked   = r_locked;

endmodule

// File: tb/tb_pixel_clk_gen.sv
// Directed bench for pixel_clk_gen: hand-computed per-cycle phase/enable/clock/busy/locked.
`timescale 1ns/1ps
module tb_pixel_clk_gen;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [3:0] divIn;
    logic       pixelEn;
    logic       pixelClk;
    logic [3:0] phase;
    logic       locked;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    pixel_clk_gen #(.CNT_WIDTH(4), .DEFAULT_DIV(4)) dut (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable),
        .divIn   (divIn),
        .pixelEn (pixelEn),
        .pixelClk(pixelClk),
        .phase   (phase),
        .locked  (locked),
        .busy    (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic outs(input string tag, input logic [3:0] ph, input logic en,
                        input logic ck, input logic bz, input logic lk);
        chk({tag, ".phase"},    {4'd0, phase},     {4'd0, ph});
        chk({tag, ".pixelEn"},  {7'd0, pixelEn},   {7'd0, en});
        chk({tag, ".pixelClk"}, {7'd0, pixelClk},  {7'd0, ck});
        chk({tag, ".busy"},     {7'd0, busy},      {7'd0, bz});
        chk({tag, ".locked"},   {7'd0, locked},    {7'd0, lk});
    endtask

    // Advance one edge, then sample 1ns later.
    task automatic tick(input string tag, input logic [3:0] ph, input logic en,
                        input logic ck, input logic bz, input logic lk);
        @(posedge clock);
        #1;
        outs(tag, ph, en, ck, bz, lk);
        if (pixelEn === 1'b1) pulses++;
    endtask

    initial begin
        reset  = 1'b0;
        enable = 1'b0;
        divIn  = 4'd4;
        #3;
        outs("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        outs("reset_hold", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick("idle", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Divide-by-4 run, 16 cycles
        enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick($sformatf("div4_c%0d", i), 4'(i % 4), (i % 4) == 3, (i % 4) >= 2, 1'b1, i >= 4);
        end
        chk("div4_pulses", 8'(pulses), 8'd4);
        $display("div4 run: %0d pulses", pulses);

        // Divisor 4->3 requested at phase 1: current period stays 4
        tick("chg_p0", 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick("chg_p1", 4'd1, 1'b0, 1'b0, 1'b1, 1'b1);
        divIn = 4'd3;
        tick("chg_p2", 4'd2, 1'b0, 1'b1, 1'b1, 1'b1);
        tick("chg_p3", 4'd3, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int p = 0; p < 2; p++) begin
            tick($sformatf("div3_%0d_p0", p), 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
            tick($sformatf("div3_%0d_p1", p), 4'd1, 1'b0, 1'b1, 1'b1, 1'b1);
            tick($sformatf("div3_%0d_p2", p), 4'd2, 1'b1, 1'b1, 1'b1, 1'b1);
        end
        $display("divisor change 4->3 applied at period boundary");

        // Drop enable at phase 1 of divide-by-5: drain to completion then idle
        divIn = 4'd5;
        tick("drn_p0", 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick("drn_p1", 4'd1, 1'b0, 1'b0, 1'b1, 1'b1);
        enable = 1'b0;
        tick("drn_p2", 4'd2, 1'b0, 1'b1, 1'b1, 1'b1);
        tick("drn_p3", 4'd3, 1'b0, 1'b1, 1'b1, 1'b1);
        tick("drn_p4", 4'd4, 1'b1, 1'b1, 1'b1, 1'b1);
        tick("drn_idle", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick("drn_idle2", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("drain from phase 1 completed, back to idle");

        // Drop at phase 2, reassert at phase 3: no gap, locked held
        enable = 1'b1;
        tick("rs_a0", 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick("rs_a1", 4'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick("rs_a2", 4'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        tick("rs_a3", 4'd3, 1'b0, 1'b1, 1'b1, 1'b0);
        tick("rs_a4", 4'd4, 1'b1, 1'b1, 1'b1, 1'b0);
        tick("rs_b0", 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick("rs_b1", 4'd1, 1'b0, 1'b0, 1'b1, 1'b1);
        tick("rs_b2", 4'd2, 1'b0, 1'b1, 1'b1, 1'b1);
        enable = 1'b0;
        tick("rs_b3", 4'd3, 1'b0, 1'b1, 1'b1, 1'b1);
        enable = 1'b1;
        tick("rs_b4", 4'd4, 1'b1, 1'b1, 1'b1, 1'b1);
        tick("rs_c0", 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick("rs_c1", 4'd1, 1'b0, 1'b0, 1'b1, 1'b1);
        $display("drain/reassert kept period 5 and lock");

        // divIn=0 and divIn=1 both give divide-by-1
        divIn = 4'd0;
        tick("d0_p2", 4'd2, 1'b0, 1'b1, 1'b1, 1'b1);
        tick("d0_p3", 4'd3, 1'b0, 1'b1, 1'b1, 1'b1);
        tick("d0_p4", 4'd4, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) tick($sformatf("div0_%0d", i), 4'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        divIn = 4'd1;
        for (int i = 0; i < 3; i++) tick($sformatf("div1_%0d", i), 4'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        $display("divisor 0 and 1 give continuous enable");

        // Maximum divisor 15, then stop exactly on the terminal edge
        divIn = 4'd15;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            tick($sformatf("d15_c%0d", i), 4'(i), i == 14, i >= 7, 1'b1, 1'b1);
        end
        chk("d15_pulses", 8'(pulses), 8'd1);
        enable = 1'b0;
        tick("d15_stop", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("divide-by-15 period and stop on terminal edge");

        // Async reset mid-period of a divide-by-4 run
        divIn  = 4'd4;
        enable = 1'b1;
        tick("rst_p0", 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick("rst_p1", 4'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick("rst_p2", 4'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        #3;
        reset = 1'b0;
        #1;
        outs("rst_async", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        outs("rst_held", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        tick("rel_p0", 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick("rel_p1", 4'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick("rel_p2", 4'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        tick("rel_p3", 4'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        tick("rel_q0", 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        $display("async reset mid-period and restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
